// File: rtl/rv32_fetch_ctrl.sv
// RV32 fetch sequencer: owns the fetch PC, issues single-outstanding imem requests,
// applies execute/trap redirects and presents one instruction slot to decode.
module rv32_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        ex_valid_in,
  input  logic        ex_branch_taken_in,
  input  logic [31:0] ex_branch_pc_in,
  input  logic        trap_valid_in,
  input  logic [31:0] trap_pc_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic        if_valid_out,
  output logic [31:0] if_pc_out,
  output logic [31:0] if_instr_out,
  output logic        if_misaligned_out,
  output logic        flush_out
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] fetch_pc_r;
  logic        slot_valid_r;
  logic [31:0] slot_pc_r;
  logic [31:0] slot_instr_r;
  logic        slot_mis_r;

  logic        redirect_s;
  logic [31:0] target_s;
  logic        consume_s;
  logic        slot_free_s;
  logic        req_s;
  logic        accept_s;
  logic        mis_fill_s;
  logic        rsp_fill_s;

  // Trap has priority over a taken branch; nothing redirects while held in reset.
  assign redirect_s  = reset & (trap_valid_in | (ex_valid_in & ex_branch_taken_in));
  assign target_s    = trap_valid_in ? trap_pc_in : ex_branch_pc_in;
  assign consume_s   = slot_valid_r & ~stall_in;
  assign slot_free_s = ~slot_valid_r | consume_s;
  assign req_s       = reset & (state_r == S_REQ) & slot_free_s & ~pc_r[1];
  assign accept_s    = req_s & imem_ready_in;
  assign mis_fill_s  = reset & (state_r == S_REQ) & slot_free_s & pc_r[1] & ~redirect_s;
  assign rsp_fill_s  = (state_r == S_WAIT) & imem_rvalid_in & ~redirect_s;

  assign imem_req_out      = req_s;
  assign imem_addr_out     = pc_r;
  assign flush_out         = redirect_s;
  assign if_valid_out      = slot_valid_r;
  assign if_pc_out         = slot_pc_r;
  assign if_instr_out      = slot_instr_r;
  assign if_misaligned_out = slot_mis_r;

  // Sequencer state, fetch PC and the decode output slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= S_REQ;
      pc_r         <= RESET_VECTOR;
      fetch_pc_r   <= 32'h0000_0000;
      slot_valid_r <= 1'b0;
      slot_pc_r    <= 32'h0000_0000;
      slot_instr_r <= 32'h0000_0000;
      slot_mis_r   <= 1'b0;
    end else begin
      case (state_r)
        S_REQ: begin
          // An address issued in a redirect cycle is stale: drain its response.
          if (accept_s) state_r <= redirect_s ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_in)  state_r <= S_REQ;
          else if (redirect_s) state_r <= S_DROP;
        end
        S_DROP: begin
          if (imem_rvalid_in) state_r <= S_REQ;
        end
        default: state_r <= S_REQ;
      endcase

      if (accept_s) fetch_pc_r <= pc_r;

      if (redirect_s)                  pc_r <= target_s;
      else if (accept_s | mis_fill_s)  pc_r <= pc_r + 32'd4;

      if (redirect_s) begin
        slot_valid_r <= 1'b0;
      end else if (rsp_fill_s) begin
        slot_valid_r <= 1'b1;
        slot_pc_r    <= fetch_pc_r;
        slot_instr_r <= imem_rdata_in;
        slot_mis_r   <= 1'b0;
      end else if (mis_fill_s) begin
        slot_valid_r <= 1'b1;
        slot_pc_r    <= pc_r;
        slot_instr_r <= NOP_INSTR;
        slot_mis_r   <= 1'b1;
      end else if (consume_s) begin
        slot_valid_r <= 1'b0;
      end
    end
  end

endmodule
